hyper_phy_scheduler: RTL and testbench
======================================

Name: hyper_phy_scheduler

Overview:
- Shares the NUM_PHYS HyperBus PHYs among NUM_REQ transaction requesters (e.g. LLC refill, DMA, debug).
- Each PHY has its own arbitration FSM with round-robin grant and ownership held until the last beat.
- Enforces a programmable CS-high gap between transactions on each PHY.
- Outputs an owner index per PHY, which drives the datapath muxes in front of the PHYs. The block never touches data.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- NUM_PHYS, 2, number of HyperBus PHYs (>=1).
- GAP_CYCLES, 4, minimum idle cycles on a PHY after a transaction ends before the next grant (0 allowed).
- TIMEOUT_CYCLES, 1024, stall limit used only with HYPER_SCHED_TIMEOUT_EN.
- Derived: REQ_W = max(1,$clog2(NUM_REQ)), PHY_W = max(1,$clog2(NUM_PHYS)).

Ports:
- clk_i  in  1  single clock (rtc/ref domain of the SoC).
- rst_i  in  1  asynchronous reset, active-high.
- req_valid_i  in  NUM_REQ  per-requester beat valid.
- req_phy_i  in  NUM_REQ*PHY_W  target PHY per requester; stable while valid.
- req_last_i  in  NUM_REQ  final beat of transaction, qualified by handshake.
- req_ready_o  out  NUM_REQ  per-requester beat accept.
- phy_valid_o  out  NUM_PHYS  beat valid toward PHY.
- phy_ready_i  in  NUM_PHYS  PHY accept.
- phy_owner_o  out  NUM_PHYS*REQ_W  current owner index per PHY (mux select).
- phy_busy_o  out  NUM_PHYS  1 in OWNED or GAP.
- timeout_o  out  NUM_PHYS  1-cycle pulse on forced release (0 when macro off).

Behaviour:
- Reset values (async on rst_i):
  - All per-PHY FSMs go to IDLE.
  - All outputs are 0, phy_owner_o = 0.
  - Round-robin pointer rr[p] = NUM_REQ-1, so requester 0 has first priority.
- Candidate set for PHY p: requesters r with req_valid_i[r]=1, req_phy_i[r]==p, and r not currently owning another PHY.
- IDLE:
  - If the candidate set is non-empty, pick the first candidate searching upward from (rr[p]+1) mod NUM_REQ, with wrap-around.
  - Register the winner into owner[p], set rr[p]=winner, go to OWNED.
  - Grant latency is 1 cycle. No beat passes in IDLE, and req_ready_o stays 0.
- OWNED:
  - phy_valid_o[p] = req_valid_i[owner] & (req_phy_i[owner]==p).
  - req_ready_o[owner] = phy_ready_i[p] under the same match condition. All other requesters see ready 0 from this PHY.
  - The path is purely combinational, with zero added latency per beat.
  - A handshake with req_last_i[owner]=1 goes to GAP, loading cnt = GAP_CYCLES. If GAP_CYCLES=0, go directly to IDLE.
  - A requester can own at most one PHY. When two PHYs in IDLE pick the same requester in one cycle, the lowest PHY index wins and the other PHY re-arbitrates next cycle.
- GAP:
  - phy_valid_o = 0, phy_busy_o = 1, cnt decrements each cycle.
  - Go to IDLE when cnt reaches 1, giving exactly GAP_CYCLES idle cycles.
  - New requests arriving during GAP wait.
- Single-beat transaction (valid & last on first handshake) is legal: OWNED lasts 1 cycle.
- Back-to-back:
  - The same requester requesting again after GAP is granted only if no other candidate exists (fairness).
  - Minimum period per PHY: 1 (grant) + beats + GAP_CYCLES.
- phy_owner_o holds its last owner in GAP/IDLE (no glitch on the mux).
- Reset mid-transaction: immediate abort to IDLE, rr restored, no handshake completes in the reset cycle.
- Owner changing req_phy_i while OWNED: protocol violation. Beats are blocked (valid/ready gated to 0) until req_phy_i returns to p.
- Outputs are combinational from FSM state and inputs, with no combinational path from phy_ready_i to phy_valid_o.

Optional Feature:
- Macro: HYPER_SCHED_TIMEOUT_EN.
- Defined:
  - A per-PHY counter clears on every handshake and on entry to OWNED, and increments each OWNED cycle without a handshake.
  - When it reaches TIMEOUT_CYCLES, the FSM force-transitions to GAP and pulses timeout_o[p] for 1 cycle.
  - The owner loses its grant and req_ready_o drops the next cycle.
- Undefined: no counter logic, timeout_o tied to 0, ownership held indefinitely.

Test Plan:
- Reset, then req 0 valid for PHY 0 with a 4-beat burst and PHY ready always 1: owner=0 one cycle after valid, 4 handshakes, then phy_busy_o high for 4 more cycles (GAP), then IDLE.
- Reqs 0,1,2 all continuously request PHY 0 with single-beat transactions: grant order 0,1,2,0,1,2, with exactly GAP_CYCLES=4 idle cycles between grants.
- Req 1 to PHY 0 and req 3 to PHY 1 in the same cycle: both granted in the same cycle and run concurrently. The owner outputs are 1 and 3.
- phy_ready_i[0] held 0 for 10 cycles mid-burst: no req_ready_o, burst resumes intact, owner unchanged.
- rst_i asserted during beat 2 of 8: all outputs 0 asynchronously. After release, req 0 is granted first despite a pending req 2.
- With HYPER_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, owner stops driving valid: timeout_o[0] pulses at stall cycle 16, PHY enters GAP, and the next requester is granted afterwards.

Source files
------------

// File: rtl/hyper_phy_scheduler.sv
// Per-PHY round-robin arbiter that shares NUM_PHYS HyperBus PHYs among NUM_REQ requesters.
// Optional stall watchdog is compiled in with `define HYPER_SCHED_TIMEOUT_EN.
module hyper_phy_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int NUM_PHYS       = 2,
   parameter int GAP_CYCLES     = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int REQ_W = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1,
   localparam int PHY_W = ($clog2(NUM_PHYS) > 1) ? $clog2(NUM_PHYS) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NUM_REQ-1:0]        req_valid_i,
   input  logic [NUM_REQ*PHY_W-1:0]  req_phy_i,
   input  logic [NUM_REQ-1:0]        req_last_i,
   output logic [NUM_REQ-1:0]        req_ready_o,
   output logic [NUM_PHYS-1:0]       phy_valid_o,
   input  logic [NUM_PHYS-1:0]       phy_ready_i,
   output logic [NUM_PHYS*REQ_W-1:0] phy_owner_o,
   output logic [NUM_PHYS-1:0]       phy_busy_o,
   output logic [NUM_PHYS-1:0]       timeout_o
);

   localparam int GCNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_OWNED, S_GAP} state_t;

   state_t            r_state     [NUM_PHYS];
   state_t            w_state_nxt [NUM_PHYS];
   logic [REQ_W-1:0]  r_owner     [NUM_PHYS];
   logic [REQ_W-1:0]  w_owner_nxt [NUM_PHYS];
   logic [REQ_W-1:0]  r_rr        [NUM_PHYS];
   logic [REQ_W-1:0]  w_rr_nxt    [NUM_PHYS];
   logic [GCNT_W-1:0] r_gap_cnt   [NUM_PHYS];
   logic [GCNT_W-1:0] w_gap_nxt   [NUM_PHYS];
`ifdef HYPER_SCHED_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0]   r_to_cnt    [NUM_PHYS];
   logic [TO_W-1:0]   w_to_nxt    [NUM_PHYS];
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int p = 0; p < NUM_PHYS; p++) begin
            r_state[p]   <= S_IDLE;
            r_owner[p]   <= '0;
            r_rr[p]      <= REQ_W'(NUM_REQ - 1);
            r_gap_cnt[p] <= '0;
`ifdef HYPER_SCHED_TIMEOUT_EN
            r_to_cnt[p]  <= '0;
`endif
         end
      end else begin
         for (int p = 0; p < NUM_PHYS; p++) begin
            r_state[p]   <= w_state_nxt[p];
            r_owner[p]   <= w_owner_nxt[p];
            r_rr[p]      <= w_rr_nxt[p];
            r_gap_cnt[p] <= w_gap_nxt[p];
`ifdef HYPER_SCHED_TIMEOUT_EN
            r_to_cnt[p]  <= w_to_nxt[p];
`endif
         end
      end
   end

   always_comb begin
      logic [NUM_REQ-1:0] w_owned;
      logic [NUM_REQ-1:0] w_claim;
      logic [REQ_W-1:0]   w_own;
      logic [REQ_W-1:0]   w_cand;
      logic [REQ_W-1:0]   w_win;
      logic               w_found;
      logic               w_match;
      logic               w_hs;
      logic               w_release;
      req_ready_o = '0;
      phy_valid_o = '0;
      phy_busy_o  = '0;
      phy_owner_o = '0;
`ifdef HYPER_SCHED_TIMEOUT_EN
      timeout_o   = '0;
`else
      timeout_o   = {NUM_PHYS{TIMEOUT_CYCLES < 0}};
`endif
      w_owned   = '0;
      w_claim   = '0;
      w_own     = '0;
      w_cand    = '0;
      w_win     = '0;
      w_found   = 1'b0;
      w_match   = 1'b0;
      w_hs      = 1'b0;
      w_release = 1'b0;

      // A requester already holding a PHY is not a candidate anywhere else.
      for (int q = 0; q < NUM_PHYS; q++)
         if (r_state[q] == S_OWNED) w_owned[r_owner[q]] = 1'b1;

      for (int p = 0; p < NUM_PHYS; p++) begin
         w_state_nxt[p] = r_state[p];
         w_owner_nxt[p] = r_owner[p];
         w_rr_nxt[p]    = r_rr[p];
         w_gap_nxt[p]   = r_gap_cnt[p];
`ifdef HYPER_SCHED_TIMEOUT_EN
         w_to_nxt[p]    = r_to_cnt[p];
`endif
         phy_owner_o[p*REQ_W +: REQ_W] = r_owner[p];
         w_own     = r_owner[p];
         w_match   = (r_state[p] == S_OWNED) && req_valid_i[w_own] &&
                     (req_phy_i[int'(w_own)*PHY_W +: PHY_W] == PHY_W'(p));
         w_hs      = w_match && phy_ready_i[p];
         w_release = 1'b0;

         case (r_state[p])
            S_IDLE: begin
               w_found = 1'b0;
               w_win   = '0;
               for (int k = 1; k <= NUM_REQ; k++) begin
                  w_cand = REQ_W'((int'(r_rr[p]) + k) % NUM_REQ);
                  if (!w_found && req_valid_i[w_cand] && !w_owned[w_cand] &&
                      (req_phy_i[int'(w_cand)*PHY_W +: PHY_W] == PHY_W'(p))) begin
                     w_found = 1'b1;
                     w_win   = w_cand;
                  end
               end
               // Same winner on two PHYs: the lower PHY index keeps it, the other retries.
               if (w_found && !w_claim[w_win]) begin
                  w_claim[w_win] = 1'b1;
                  w_state_nxt[p] = S_OWNED;
                  w_owner_nxt[p] = w_win;
                  w_rr_nxt[p]    = w_win;
`ifdef HYPER_SCHED_TIMEOUT_EN
                  w_to_nxt[p]    = '0;
`endif
               end
            end
            S_OWNED: begin
               phy_busy_o[p]  = 1'b1;
               phy_valid_o[p] = w_match;
               if (w_hs) req_ready_o[w_own] = 1'b1;
               w_release = w_hs && req_last_i[w_own];
`ifdef HYPER_SCHED_TIMEOUT_EN
               if (w_hs) begin
                  w_to_nxt[p] = '0;
               end else if (r_to_cnt[p] == TO_W'(TIMEOUT_CYCLES - 1)) begin
                  timeout_o[p] = 1'b1;
                  w_to_nxt[p]  = '0;
                  w_release    = 1'b1;
               end else begin
                  w_to_nxt[p]  = r_to_cnt[p] + TO_W'(1);
               end
`endif
               if (w_release) begin
                  if (GAP_CYCLES == 0) begin
                     w_state_nxt[p] = S_IDLE;
                  end else begin
                     w_state_nxt[p] = S_GAP;
                     w_gap_nxt[p]   = GCNT_W'(GAP_CYCLES);
                  end
               end
            end
            S_GAP: begin
               phy_busy_o[p] = 1'b1;
               w_gap_nxt[p]  = r_gap_cnt[p] - GCNT_W'(1);
               if (r_gap_cnt[p] <= GCNT_W'(1)) w_state_nxt[p] = S_IDLE;
            end
            default: w_state_nxt[p] = S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hyper_phy_scheduler.sv
// Scoreboard bench for hyper_phy_scheduler: expected grants (PHY, owner, cycle) are queued
// when requests are driven and popped when the DUT's busy flag rises on that PHY.
module tb_hyper_phy_scheduler;

   localparam int NUM_REQ  = 4;
   localparam int NUM_PHYS = 2;
   localparam int REQ_W    = 2;
   localparam int PHY_W    = 1;
   localparam int GAP      = 4;
   localparam int TO_LIMIT = 16;
   localparam int PERIOD1  = 1 + 1 + GAP;
`ifdef HYPER_SCHED_TIMEOUT_EN
   localparam int EXP_TO   = 1;
`else
   localparam int EXP_TO   = 0;
`endif

   logic                      clk_i = 1'b0;
   logic                      rst_i = 1'b0;
   logic [NUM_REQ-1:0]        req_valid_i;
   logic [NUM_REQ*PHY_W-1:0]  req_phy_i;
   logic [NUM_REQ-1:0]        req_last_i;
   logic [NUM_REQ-1:0]        req_ready_o;
   logic [NUM_PHYS-1:0]       phy_valid_o;
   logic [NUM_PHYS-1:0]       phy_ready_i;
   logic [NUM_PHYS*REQ_W-1:0] phy_owner_o;
   logic [NUM_PHYS-1:0]       phy_busy_o;
   logic [NUM_PHYS-1:0]       timeout_o;

   always #5 clk_i = ~clk_i;

   hyper_phy_scheduler #(
      .NUM_REQ(NUM_REQ), .NUM_PHYS(NUM_PHYS), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO_LIMIT)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_phy_i(req_phy_i), .req_last_i(req_last_i),
      .req_ready_o(req_ready_o), .phy_valid_o(phy_valid_o), .phy_ready_i(phy_ready_i),
      .phy_owner_o(phy_owner_o), .phy_busy_o(phy_busy_o), .timeout_o(timeout_o)
   );

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct packed { int cyc; int owner; } grant_t;
   grant_t q_exp0[$];
   grant_t q_exp1[$];

   int n_checks = 0;
   int n_fail   = 0;

   int rq_len [NUM_REQ];
   int rq_beat[NUM_REQ];
   int rq_txn [NUM_REQ];
   int rq_phy [NUM_REQ];
   bit rq_stall[NUM_REQ];
   int hs_cnt [NUM_REQ];
   int busy_cnt0, both_valid, rdy_cnt, to_test, to_cyc, to_total, k, rdy_mark;
   logic [NUM_PHYS-1:0] prev_busy = '0;

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic drive_reqs();
      for (int r = 0; r < NUM_REQ; r++) begin
         req_valid_i[r] = (rq_txn[r] > 0) && !rq_stall[r];
         req_phy_i[r*PHY_W +: PHY_W] = PHY_W'(rq_phy[r]);
         req_last_i[r] = (rq_beat[r] == rq_len[r] - 1);
      end
   endtask

   task automatic set_req(input int r, input int phy, input int len, input int txn);
      rq_phy[r] = phy; rq_len[r] = len; rq_txn[r] = txn; rq_beat[r] = 0; rq_stall[r] = 1'b0;
   endtask

   task automatic clear_reqs();
      for (int r = 0; r < NUM_REQ; r++) set_req(r, 0, 1, 0);
      drive_reqs();
   endtask

   task automatic start_test();
      for (int r = 0; r < NUM_REQ; r++) hs_cnt[r] = 0;
      busy_cnt0 = 0; both_valid = 0; rdy_cnt = 0; to_test = 0; to_cyc = -1;
   endtask

   task automatic push_grant(input int p, input int c, input int o);
      grant_t g;
      g.cyc = c; g.owner = o;
      if (p == 0) q_exp0.push_back(g); else q_exp1.push_back(g);
   endtask

   task automatic grant_seen(input int p);
      grant_t g;
      int     own;
      own = int'(phy_owner_o[p*REQ_W +: REQ_W]);
      if ((p == 0 && q_exp0.size() == 0) || (p == 1 && q_exp1.size() == 0)) begin
         check_eq($sformatf("p%0d_unexpected_grant_owner", p), own, -1);
         return;
      end
      g = (p == 0) ? q_exp0.pop_front() : q_exp1.pop_front();
      check_eq($sformatf("p%0d_grant_owner", p), own, g.owner);
      check_eq($sformatf("p%0d_grant_cycle", p), cyc, g.cyc);
   endtask

   task automatic step();
      logic [NUM_REQ-1:0] hs;
      @(negedge clk_i);
      for (int p = 0; p < NUM_PHYS; p++)
         if (phy_busy_o[p] && !prev_busy[p]) grant_seen(p);
      prev_busy = phy_busy_o;
      if (phy_busy_o[0]) busy_cnt0++;
      if (&phy_valid_o) both_valid++;
      if (req_ready_o != '0) rdy_cnt++;
      if (timeout_o != '0) begin to_test++; to_total++; to_cyc = cyc; end
      hs = req_valid_i & req_ready_o;
      @(posedge clk_i);
      #1;
      for (int r = 0; r < NUM_REQ; r++) begin
         if (hs[r]) begin
            hs_cnt[r]++;
            rq_beat[r]++;
            if (rq_beat[r] == rq_len[r]) begin rq_beat[r] = 0; rq_txn[r]--; end
         end
      end
      drive_reqs();
   endtask

   // Called at posedge+1; asserts reset mid-cycle and checks outputs asynchronously.
   task automatic do_reset(input bit clr, input string tag);
      #2 rst_i = 1'b1;
      #1;
      check_eq({tag, "_ready"}, req_ready_o, 0);
      check_eq({tag, "_valid"}, phy_valid_o, 0);
      check_eq({tag, "_busy"},  phy_busy_o, 0);
      check_eq({tag, "_owner"}, phy_owner_o, 0);
      check_eq({tag, "_timeout"}, timeout_o, 0);
      if (clr) clear_reqs();
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      prev_busy = '0;
   endtask

   task automatic check_drained(input string tag);
      check_eq({tag, "_pending_p0"}, q_exp0.size(), 0);
      check_eq({tag, "_pending_p1"}, q_exp1.size(), 0);
   endtask

   initial begin
      to_total = 0;
      req_valid_i = '0; req_phy_i = '0; req_last_i = '0;
      phy_ready_i = '1;
      clear_reqs();
      @(posedge clk_i); #1;

      // T1: single 4-beat burst, then GAP, then idle
      do_reset(1'b1, "t1_rst");
      start_test();
      set_req(0, 0, 4, 1); drive_reqs(); k = cyc;
      push_grant(0, k + 1, 0);
      repeat (16) step();
      check_eq("t1_beats", hs_cnt[0], 4);
      check_eq("t1_busy_cycles", busy_cnt0, 4 + GAP);
      check_eq("t1_idle_busy", phy_busy_o[0], 0);
      check_drained("t1");

      // T2: three requesters, single beats, round-robin order 0,1,2,0,1,2
      do_reset(1'b1, "t2_rst");
      start_test();
      for (int r = 0; r < 3; r++) set_req(r, 0, 1, 2);
      drive_reqs(); k = cyc;
      for (int i = 0; i < 6; i++) push_grant(0, k + 1 + i * PERIOD1, i % 3);
      repeat (42) step();
      for (int r = 0; r < 3; r++) check_eq($sformatf("t2_beats_r%0d", r), hs_cnt[r], 2);
      check_eq("t2_busy_cycles", busy_cnt0, 6 * (1 + GAP));
      check_drained("t2");

      // T3: req1 on PHY0 and req3 on PHY1 granted together, run concurrently
      do_reset(1'b1, "t3_rst");
      start_test();
      set_req(1, 0, 3, 1); set_req(3, 1, 3, 1); drive_reqs(); k = cyc;
      push_grant(0, k + 1, 1); push_grant(1, k + 1, 3);
      repeat (14) step();
      check_eq("t3_beats_r1", hs_cnt[1], 3);
      check_eq("t3_beats_r3", hs_cnt[3], 3);
      check_eq("t3_concurrent_cycles", both_valid, 3);
      check_eq("t3_busy_cycles_p0", busy_cnt0, 3 + GAP);
      check_drained("t3");

      // T4: PHY0 back-pressure for 10 cycles in the middle of an 8-beat burst
      do_reset(1'b1, "t4_rst");
      start_test();
      set_req(2, 0, 8, 1); drive_reqs(); k = cyc;
      push_grant(0, k + 1, 2);
      repeat (5) step();
      check_eq("t4_beats_before_stall", hs_cnt[2], 4);
      phy_ready_i[0] = 1'b0;
      rdy_mark = rdy_cnt;
      repeat (10) step();
      check_eq("t4_ready_during_stall", rdy_cnt - rdy_mark, 0);
      check_eq("t4_owner_during_stall", phy_owner_o[REQ_W-1:0], 2);
      check_eq("t4_busy_during_stall", phy_busy_o[0], 1);
      phy_ready_i[0] = 1'b1;
      repeat (22) step();
      check_eq("t4_beats_total", hs_cnt[2], 8);
      check_eq("t4_busy_cycles", busy_cnt0, 18 + GAP);
      check_drained("t4");

      // T5: reset mid-burst; afterwards req0 wins over still-pending req2
      do_reset(1'b1, "t5_rst");
      start_test();
      set_req(2, 0, 8, 1); drive_reqs(); k = cyc;
      push_grant(0, k + 1, 2);
      repeat (4) step();
      set_req(0, 0, 1, 1); drive_reqs();
      do_reset(1'b0, "t5_midburst_rst");
      k = cyc;
      push_grant(0, k + 1, 0);
      repeat (4) step();
      check_eq("t5_beats_r0", hs_cnt[0], 1);
      check_eq("t5_beats_r2", hs_cnt[2], 3);
      check_drained("t5");

`ifdef HYPER_SCHED_TIMEOUT_EN
      // T6: owner stops driving valid; watchdog releases PHY0 after 16 stall cycles
      do_reset(1'b1, "t6_rst");
      start_test();
      set_req(0, 0, 4, 1); set_req(1, 0, 1, 1); drive_reqs(); k = cyc;
      push_grant(0, k + 1, 0);
      push_grant(0, k + 7 + 2 * 8 - 1 + GAP + 1 - 4, 1);
      repeat (2) step();
      rq_stall[0] = 1'b1; drive_reqs();
      repeat (32) step();
      check_eq("t6_timeout_pulses", to_test, 1);
      check_eq("t6_timeout_cycle", to_cyc, k + 17);
      check_eq("t6_beats_r0", hs_cnt[0], 1);
      check_eq("t6_beats_r1", hs_cnt[1], 1);
      check_drained("t6");
`endif

      check_eq("timeout_pulses_total", to_total, EXP_TO);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
